sample_sequencer: RTL and testbench

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

---
 rtl/sample_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sample_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sequencer.sv
// sample_sequencer
//   Generates a periodic sample tick and runs one acquisition sequence per
//   tick: ADC start -> wait for conversion -> control start -> wait for the
//   control law -> PWM duty reload. Each wait is bounded by a timer. Late
//   ticks and expired waits are latched in sticky flags.
//
// Ports
//   clk_in        system clock, all logic on posedge
//   rst           synchronous active-high reset
//   enable        tick generation runs while high
//   divisor_in    new tick period (clk_in cycles)
//   divisor_load  strobe, captures divisor_in into the shadow period
//   adc_done      ADC conversion-complete pulse
//   ctrl_done     control-law-complete pulse
//   clear_err     clears overrun and timeout_err
//   tick_out      one-cycle period tick
//   adc_start     one-cycle ADC start pulse
//   ctrl_start    one-cycle control start pulse
//   pwm_update    one-cycle PWM reload pulse
//   busy          sequence in progress (FSM not IDLE)
//   overrun       sticky, tick arrived while busy
//   timeout_err   sticky, a wait state expired
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for a tick
// ADC_WAIT  | adc_start issued, waiting for adc_done
// CTRL_WAIT | ctrl_start issued, waiting for ctrl_done
// UPDATE    | pwm_update issued, returns to IDLE next cycle

module sample_sequencer #(
    parameter logic [15:0] DIVISOR = 16'd6250,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] divisor_in,
    input  logic        divisor_load,
    input  logic        adc_done,
    input  logic        ctrl_done,
    input  logic        clear_err,
    output logic        tick_out,
    output logic        adc_start,
    output logic        ctrl_start,
    output logic        pwm_update,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADC_WAIT  = 2'd1,
        CTRL_WAIT = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Period counter and divisor shadowing
    // ------------------------------------------------------------------
    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] shadow_div;
    logic [15:0] active_div;
    logic [15:0] div_next;
    logic        wrap;

    assign wrap = (count == active_div - 16'd1);

    // The new period is only taken at a wrap (or while stopped), so the
    // period in flight is never cut short or stretched.
    always_comb begin
        count_next = 16'd0;
        div_next   = active_div;
        if (!enable) begin
            count_next = 16'd0;
            div_next   = shadow_div;
        end else if (wrap) begin
            count_next = 16'd0;
            div_next   = shadow_div;
        end else begin
            count_next = count + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count      <= 16'd0;
            shadow_div <= DIVISOR;
            active_div <= DIVISOR;
            tick_out   <= 1'b0;
        end else begin
            count      <= count_next;
            active_div <= div_next;
            if (divisor_load) begin
                shadow_div <= (divisor_in < 16'd2) ? 16'd2 : divisor_in;
            end
            // Registered tick: high in exactly the cycle whose counter value
            // is the last of the period.
            tick_out <= enable && (count_next == div_next - 16'd1);
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [15:0] wait_timer;
    logic        expired;
    logic        timeout_evt;
    logic        overrun_evt;

    logic        adc_start_d;
    logic        ctrl_start_d;
    logic        pwm_update_d;
    logic        busy_d;
    logic        overrun_d;
    logic        timeout_err_d;

    // Expiry is flagged on the cycle the timer is about to reach TIMEOUT,
    // which bounds a wait to TIMEOUT cycles in the state.
    assign expired = (wait_timer == TIMEOUT - 16'd1);

    // State register, wait timer and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            wait_timer  <= 16'd0;
            adc_start   <= 1'b0;
            ctrl_start  <= 1'b0;
            pwm_update  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if ((state_next != state) &&
                ((state_next == ADC_WAIT) || (state_next == CTRL_WAIT))) begin
                wait_timer <= 16'd0;
            end else if ((state == ADC_WAIT) || (state == CTRL_WAIT)) begin
                wait_timer <= wait_timer + 16'd1;
            end
            adc_start   <= adc_start_d;
            ctrl_start  <= ctrl_start_d;
            pwm_update  <= pwm_update_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state logic; a done pulse beats a simultaneous expiry.
    always_comb begin
        state_next  = state;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (tick_out) begin
                    state_next = ADC_WAIT;
                end
            end
            ADC_WAIT: begin
                if (adc_done) begin
                    state_next = CTRL_WAIT;
                end else if (expired) begin
                    state_next  = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            CTRL_WAIT: begin
                if (ctrl_done) begin
                    state_next = UPDATE;
                end else if (expired) begin
                    state_next  = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs. Set events on
    // the sticky flags take priority over clear_err.
    always_comb begin
        adc_start_d  = (state == IDLE) && tick_out;
        ctrl_start_d = (state == ADC_WAIT) && adc_done;
        pwm_update_d = (state == CTRL_WAIT) && ctrl_done;
        busy_d       = (state_next != IDLE);
        overrun_evt  = tick_out && (state != IDLE);

        overrun_d = overrun;
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end

        timeout_err_d = timeout_err;
        if (timeout_evt) begin
            timeout_err_d = 1'b1;
        end else if (clear_err) begin
            timeout_err_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer
//   Directed bench for sample_sequencer. Two instances share one set of
//   inputs: dut (DIVISOR=10, TIMEOUT=20) for the period, divisor, overrun and
//   reset scenarios, and dut_to (DIVISOR=10, TIMEOUT=8) for the wait-timeout
//   scenarios. A cycle table covers one full acquisition sequence; the
//   multi-cycle corner cases are hand-written loops.

module tb_sample_sequencer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] divisor_in = 16'd0;
    logic        divisor_load = 1'b0;
    logic        adc_done = 1'b0;
    logic        ctrl_done = 1'b0;
    logic        clear_err = 1'b0;

    logic tick_out, adc_start, ctrl_start, pwm_update, busy, overrun, timeout_err;
    logic to_tick, to_adc_start, to_ctrl_start, to_pwm, to_busy, to_overrun, to_terr;

    int checks = 0;
    int failures = 0;

    sample_sequencer #(.DIVISOR(16'd10), .TIMEOUT(16'd20)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .divisor_in   (divisor_in),
        .divisor_load (divisor_load),
        .adc_done     (adc_done),
        .ctrl_done    (ctrl_done),
        .clear_err    (clear_err),
        .tick_out     (tick_out),
        .adc_start    (adc_start),
        .ctrl_start   (ctrl_start),
        .pwm_update   (pwm_update),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    sample_sequencer #(.DIVISOR(16'd10), .TIMEOUT(16'd8)) dut_to (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .divisor_in   (divisor_in),
        .divisor_load (divisor_load),
        .adc_done     (adc_done),
        .ctrl_done    (ctrl_done),
        .clear_err    (clear_err),
        .tick_out     (to_tick),
        .adc_start    (to_adc_start),
        .ctrl_start   (to_ctrl_start),
        .pwm_update   (to_pwm),
        .busy         (to_busy),
        .overrun      (to_overrun),
        .timeout_err  (to_terr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       adc_done;
        logic       ctrl_done;
        logic [6:0] exp;   // {tick, adc_start, ctrl_start, pwm_update, busy, overrun, timeout_err}
    } vec_t;

    vec_t vecs[22];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Leaves the bench in cycle 0: registers hold reset values, rst is low
    // and enable is high, so cycle k has counter value k.
    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        divisor_load = 1'b0;
        adc_done     = 1'b0;
        ctrl_done    = 1'b0;
        clear_err    = 1'b0;
        step();
        step();
        rst    = 1'b0;
        enable = 1'b1;
    endtask

    // At most one start/update pulse per cycle
    always @(negedge clk_in) begin
        if (!rst) begin
            checks++;
            if ((32'(adc_start) + 32'(ctrl_start) + 32'(pwm_update)) > 1) begin
                failures++;
                $display("FAIL pulse_onehot actual=%b%b%b expected=at most one",
                         adc_start, ctrl_start, pwm_update);
            end
        end
    end

    initial begin
        int ticks[$];
        logic seen;

        // Cycle table: adc_done 3 cycles after adc_start, ctrl_done 5 cycles
        // after ctrl_start. adc_done at 5 (IDLE) and ctrl_done at 12
        // (ADC_WAIT) must be ignored. The tick at 19 lands in CTRL_WAIT.
        vecs[0]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[1]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[2]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[3]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[4]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[5]  = '{1'b1, 1'b0, 7'b0000000};
        vecs[6]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[7]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[8]  = '{1'b0, 1'b0, 7'b0000000};
        vecs[9]  = '{1'b0, 1'b0, 7'b1000000};
        vecs[10] = '{1'b0, 1'b0, 7'b0100100};
        vecs[11] = '{1'b0, 1'b0, 7'b0000100};
        vecs[12] = '{1'b0, 1'b1, 7'b0000100};
        vecs[13] = '{1'b1, 1'b0, 7'b0000100};
        vecs[14] = '{1'b0, 1'b0, 7'b0010100};
        vecs[15] = '{1'b0, 1'b0, 7'b0000100};
        vecs[16] = '{1'b0, 1'b0, 7'b0000100};
        vecs[17] = '{1'b0, 1'b0, 7'b0000100};
        vecs[18] = '{1'b0, 1'b0, 7'b0000100};
        vecs[19] = '{1'b0, 1'b1, 7'b1000100};
        vecs[20] = '{1'b0, 1'b0, 7'b0001110};
        vecs[21] = '{1'b0, 1'b0, 7'b0000010};

        // ---- cycle table -------------------------------------------------
        do_reset();
        for (int i = 0; i < 22; i++) begin
            check($sformatf("table_c%0d", i),
                  int'({tick_out, adc_start, ctrl_start, pwm_update, busy, overrun, timeout_err}),
                  int'(vecs[i].exp));
            adc_done  = vecs[i].adc_done;
            ctrl_done = vecs[i].ctrl_done;
            step();
        end
        adc_done  = 1'b0;
        ctrl_done = 1'b0;

        // ---- divisor reload: 20 loaded at counter 3, then 0 at a wrap -----
        do_reset();
        ticks.delete();
        divisor_in = 16'd20;
        for (int c = 0; c < 80; c++) begin
            if (tick_out) ticks.push_back(c);
            divisor_load = (c == 3) || (c == 49);
            if (c == 49) divisor_in = 16'd0;
            step();
        end
        divisor_load = 1'b0;
        check("div_tick0", (ticks.size() > 0) ? ticks[0] : -1, 9);
        check("div_tick1", (ticks.size() > 1) ? ticks[1] : -1, 29);
        check("div_tick2", (ticks.size() > 2) ? ticks[2] : -1, 49);
        check("div_tick3", (ticks.size() > 3) ? ticks[3] : -1, 69);
        check("div_tick4", (ticks.size() > 4) ? ticks[4] : -1, 71);
        check("div_tick5", (ticks.size() > 5) ? ticks[5] : -1, 73);

        // ---- enable low: no ticks, divisor applies at once ---------------
        do_reset();
        ticks.delete();
        enable     = 1'b0;
        divisor_in = 16'd5;
        for (int c = 0; c < 36; c++) begin
            if (tick_out) ticks.push_back(c);
            divisor_load = (c == 2);
            if (c == 20) enable = 1'b1;
            step();
        end
        divisor_load = 1'b0;
        check("en_tick0", (ticks.size() > 0) ? ticks[0] : -1, 24);
        check("en_tick1", (ticks.size() > 1) ? ticks[1] : -1, 29);
        check("en_tick2", (ticks.size() > 2) ? ticks[2] : -1, 34);

        // ---- wait timeout on dut_to (TIMEOUT=8) --------------------------
        do_reset();
        seen = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            adc_done  = 1'b0;
            clear_err = 1'b0;
            if (c < 38) seen = seen | to_ctrl_start | to_pwm;
            case (c)
                10: check("to_adc_start0", int'(to_adc_start), 1);
                17: begin
                    check("to_busy_last", int'(to_busy), 1);
                    check("to_err_before", int'(to_terr), 0);
                end
                18: begin
                    check("to_err_set", int'(to_terr), 1);
                    check("to_busy_idle", int'(to_busy), 0);
                end
                20: begin
                    check("to_adc_start1", int'(to_adc_start), 1);
                    check("to_no_overrun", int'(to_overrun), 0);
                    clear_err = 1'b1;
                end
                21: check("to_err_cleared", int'(to_terr), 0);
                27: clear_err = 1'b1;
                28: check("to_err_clear_vs_set", int'(to_terr), 1);
                30: begin
                    check("to_adc_start2", int'(to_adc_start), 1);
                    clear_err = 1'b1;
                end
                31: check("to_err_cleared2", int'(to_terr), 0);
                37: adc_done = 1'b1;
                38: begin
                    check("to_done_wins_ctrl", int'(to_ctrl_start), 1);
                    check("to_done_wins_err", int'(to_terr), 0);
                end
                default: ;
            endcase
            step();
        end
        adc_done  = 1'b0;
        clear_err = 1'b0;
        check("to_no_ctrl_or_pwm", int'(seen), 0);

        // ---- overrun: ctrl_done 15 cycles after ctrl_start ---------------
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            adc_done  = (c == 13);
            ctrl_done = (c == 29);
            clear_err = (c == 32);
            case (c)
                14: check("ov_ctrl_start", int'(ctrl_start), 1);
                19: check("ov_before_tick2", int'(overrun), 0);
                20: begin
                    check("ov_set", int'(overrun), 1);
                    check("ov_tick_dropped", int'(adc_start), 0);
                end
                30: begin
                    check("ov_pwm", int'(pwm_update), 1);
                    check("ov_tick3_dropped", int'(adc_start), 0);
                end
                31: check("ov_idle", int'(busy), 0);
                32: check("ov_sticky", int'(overrun), 1);
                33: begin
                    check("ov_cleared", int'(overrun), 0);
                    check("ov_no_timeout", int'(timeout_err), 0);
                end
                default: ;
            endcase
            step();
        end
        adc_done  = 1'b0;
        ctrl_done = 1'b0;
        clear_err = 1'b0;

        // ---- reset pulse in CTRL_WAIT with a 20-cycle period active ------
        do_reset();
        seen = 1'b0;
        divisor_in = 16'd20;
        for (int c = 0; c <= 28; c++) begin
            divisor_load = (c == 3);
            adc_done     = (c == 13);
            rst          = (c == 16);
            ctrl_done    = (c == 18);
            if (c >= 17 && c <= 25)
                seen = seen | busy | ctrl_start | pwm_update | tick_out;
            case (c)
                14: check("rs_ctrl_start", int'(ctrl_start), 1);
                16: check("rs_busy_before", int'(busy), 1);
                17: check("rs_outputs_zero",
                          int'({tick_out, adc_start, ctrl_start, pwm_update, busy, overrun, timeout_err}), 0);
                26: check("rs_tick_default_div", int'(tick_out), 1);
                27: check("rs_adc_start", int'(adc_start), 1);
                default: ;
            endcase
            step();
        end
        divisor_load = 1'b0;
        adc_done     = 1'b0;
        ctrl_done    = 1'b0;
        check("rs_quiet_after_reset", int'(seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
